spram_16kx16: RTL and testbench
===============================

Name: spram_16kx16

Overview:
- Behavioural single-port synchronous RAM, 16384 x 16 bit, with per-nibble write masking and low-power controls.
- Matches the iCE40 UltraPlus SPRAM hard macro.
- Used in pairs (low/high halfword) to build 32-bit main RAM banks: shared address, independent write enables and byte selects.

Parameters:
- ADDR_W, 14, address width; depth = 2**ADDR_W words.
- INIT_ZERO, 0, when 1 the simulation array is initialised to 0 at time zero; when 0 it is left uninitialised (X).

Ports:
- clk  in  1  rising-edge clock for all accesses.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  word address.
- wrdata  in  16  write data.
- maskwe  in  4  nibble write enables; bit i enables wrdata[4i+3:4i].
- we  in  1  1 = write cycle, 0 = read cycle.
- cs  in  1  chip select; 0 = no access.
- stdby  in  1  standby: no access, data retained.
- sleep  in  1  sleep: no access, data retained, rddata forced 0.
- pwroff_n  in  1  0 = powered off, data lost, rddata forced 0.
- rddata  out  16  registered read data.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset: rst_n low clears the rddata register to 16'h0000 immediately and holds it there while low. No access occurs while rst_n is low. The memory array is not affected by reset.
- Access enable: act = cs & ~stdby & ~sleep & pwroff_n & rst_n, sampled at the rising edge of clk.
- Write (act & we):
  - For each i in 0..3 with maskwe[i]=1, mem[addr][4i+3:4i] <= wrdata[4i+3:4i].
  - Nibbles with maskwe[i]=0 are unchanged.
  - maskwe=0000 with we=1 is a no-op write.
  - rddata holds its previous value during a write cycle; there is no write-through.
- Read (act & ~we): rddata <= mem[addr] at the clock edge, so data is valid 1 cycle after the address is presented.
  - Back-to-back reads pipeline at one word per cycle.
  - A read in the cycle after a write to the same address returns the newly written data.
- No access (act=0 via cs=0 or stdby=1): rddata holds, memory unchanged.
- Output-forcing priority (highest first):
  1. rst_n=0: rddata = 0.
  2. pwroff_n=0: rddata = 0.
  3. sleep=1: rddata = 0.
  4. stdby=1 or cs=0: rddata holds.
  5. Otherwise: normal access.
  - Forcing takes effect at the next clock edge (synchronous) except reset, which is asynchronous.
- Leaving sleep or stdby: the access is valid on the first edge where the condition is gone. There is no wake-up delay. Contents are retained.
- Power-off: while pwroff_n=0, contents are lost. After pwroff_n returns to 1, a read of any word not rewritten since then returns an undefined value; the model drives X, and benches treat it as don't-care.
- Address: always in range (full 2**ADDR_W decode). No wrap or aliasing logic is needed.
- Simultaneous events: stdby/sleep/pwroff_n asserted in the same cycle as we=1 suppress the write.

Test Plan:
- Full write then read: rst_n 0->1; write addr 0x0000=16'h0101 and addr 0x3FFF=16'h4302 with maskwe=1111; read both -> rddata 16'h0101, then 16'h4302, each 1 cycle after its address.
- Nibble mask: addr 5 holds 16'hFFFF; write 16'h1234 with maskwe=0101 -> read returns 16'hF2F4. Then maskwe=0000 with data 16'h0000 -> read still 16'hF2F4.
- Write cycle holds output: read addr 5 (rddata=16'hF2F4), then write addr 6=16'hAAAA -> rddata stays 16'hF2F4 during the write; next read of addr 6 -> 16'hAAAA.
- cs/stdby gating: cs=0 with we=1 writing 16'h5555 to addr 6 -> addr 6 still 16'hAAAA, rddata unchanged. stdby=1 behaves the same.
- Sleep: sleep=1 -> rddata=0 from the next edge, and a write of 16'h0F0F to addr 6 is ignored. sleep=0 -> reading addr 6 returns 16'hAAAA.
- Async reset mid-operation: assert rst_n low between clock edges while rddata=16'hAAAA -> rddata=0 immediately. After release, reading addr 5 returns 16'hF2F4 (contents retained).

Source files
------------

// File: rtl/spram_16kx16.sv
// Behavioural 16K x 16 single-port RAM with nibble write masks and
// standby / sleep / power-off controls, modelled on the iCE40UP SPRAM.
module spram_16kx16 #(
    parameter int ADDR_W    = 14,
    parameter int INIT_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wrdata,
    input  logic [3:0]        maskwe,
    input  logic              we,
    input  logic              cs,
    input  logic              stdby,
    input  logic              sleep,
    input  logic              pwroff_n,
    output logic [15:0]       rddata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] FILL = (INIT_ZERO != 0) ? 4'h0 : 4'hx;

    logic [15:0]        mem [DEPTH];
    // One flag per nibble: cleared on power-off, set when the nibble is written.
    logic [4*DEPTH-1:0] vld_q;

    logic [15:0] rddata_q, rddata_d;
    logic [15:0] rd_word;
    logic        act;
    logic        wr_en;

    always_comb begin
        act   = cs & ~stdby & ~sleep & pwroff_n;
        wr_en = act & we;
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (vld_q[{addr, 2'(i)}])
                rd_word[4*i +: 4] = mem[addr][4*i +: 4];
            else
                rd_word[4*i +: 4] = FILL;
        end
    end

    always_comb begin
        rddata_d = rddata_q;
        if (!pwroff_n || sleep)
            rddata_d = '0;
        else if (act && !we)
            rddata_d = rd_word;
    end

    // Array and valid flags are deliberately left out of the reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rddata_q <= '0;
        end else begin
            rddata_q <= rddata_d;
            if (!pwroff_n) begin
                vld_q <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (maskwe[i]) begin
                        mem[addr][4*i +: 4]   <= wrdata[4*i +: 4];
                        vld_q[{addr, 2'(i)}] <= 1'b1;
                    end
                end
            end
        end
    end

    assign rddata = rddata_q;

endmodule

// File: tb/tb_spram_16kx16.sv
// Directed self-checking bench for spram_16kx16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_spram_16kx16;

    logic        clk;
    logic        rst_n;
    logic [13:0] addr;
    logic [15:0] wrdata;
    logic [3:0]  maskwe;
    logic        we;
    logic        cs;
    logic        stdby;
    logic        sleep;
    logic        pwroff_n;
    logic [15:0] rddata;

    int checks   = 0;
    int failures = 0;

    spram_16kx16 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .wrdata   (wrdata),
        .maskwe   (maskwe),
        .we       (we),
        .cs       (cs),
        .stdby    (stdby),
        .sleep    (sleep),
        .pwroff_n (pwroff_n),
        .rddata   (rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d,
                      input logic [3:0] m);
        cs = 1'b1; we = 1'b1; addr = a; wrdata = d; maskwe = m;
        step();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a);
        cs = 1'b1; we = 1'b0; addr = a;
        step();
        cs = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; wrdata = '0; maskwe = '0;
        we = 1'b0; cs = 1'b0; stdby = 1'b0; sleep = 1'b0; pwroff_n = 1'b1;
        step();
        step();
        chk("reset", rddata, 16'h0000);
        rst_n = 1'b1;
        step();
        chk("post_reset_idle", rddata, 16'h0000);

        wr(14'h0000, 16'h0101, 4'b1111);
        wr(14'h3FFF, 16'h4302, 4'b1111);
        rd(14'h0000);
        chk("rd_addr0", rddata, 16'h0101);
        rd(14'h3FFF);
        chk("rd_addr_top", rddata, 16'h4302);

        wr(14'h0005, 16'hFFFF, 4'b1111);
        wr(14'h0005, 16'h1234, 4'b0101);
        rd(14'h0005);
        chk("nibble_mask", rddata, 16'hF2F4);
        wr(14'h0005, 16'h0000, 4'b0000);
        rd(14'h0005);
        chk("mask_zero_noop", rddata, 16'hF2F4);

        rd(14'h0005);
        chk("rd_before_wr", rddata, 16'hF2F4);
        wr(14'h0006, 16'hAAAA, 4'b1111);
        chk("wr_holds_out", rddata, 16'hF2F4);
        rd(14'h0006);
        chk("rd_after_wr", rddata, 16'hAAAA);

        cs = 1'b0; we = 1'b1; addr = 14'h0006; wrdata = 16'h5555; maskwe = 4'hF;
        step();
        chk("cs0_hold", rddata, 16'hAAAA);
        cs = 1'b1; stdby = 1'b1;
        step();
        chk("stdby_hold", rddata, 16'hAAAA);
        stdby = 1'b0; cs = 1'b0; we = 1'b0;
        rd(14'h0006);
        chk("gated_no_write", rddata, 16'hAAAA);

        cs = 1'b1; we = 1'b1; sleep = 1'b1;
        addr = 14'h0006; wrdata = 16'h0F0F; maskwe = 4'hF;
        step();
        chk("sleep_zero", rddata, 16'h0000);
        sleep = 1'b0; cs = 1'b0; we = 1'b0;
        rd(14'h0006);
        chk("sleep_no_write", rddata, 16'hAAAA);

        stdby = 1'b1;
        step();
        stdby = 1'b0;
        rd(14'h0000);
        chk("stdby_exit", rddata, 16'h0101);

        rd(14'h0006);
        chk("pre_async_rst", rddata, 16'hAAAA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", rddata, 16'h0000);
        step();
        rst_n = 1'b1;
        rd(14'h0005);
        chk("retained", rddata, 16'hF2F4);

        wr(14'h0007, 16'h1111, 4'b1111);
        pwroff_n = 1'b0;
        step();
        chk("pwroff_zero", rddata, 16'h0000);
        pwroff_n = 1'b1;
        wr(14'h0007, 16'h00AB, 4'b0011);
        rd(14'h0007);
        chk("pwroff_rewrite", {8'h00, rddata[7:0]}, 16'h00AB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
